// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite widths, response codes and master FSM state encoding.
package axi_lite_pkg;

   localparam int AXI_ADDR_W = 32;
   localparam int AXI_DATA_W = 32;
   localparam int AXI_STRB_W = AXI_DATA_W / 8;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_EXOKAY = 2'b01,
      RESP_SLVERR = 2'b10,
      RESP_DECERR = 2'b11
   } resp_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_AW,
      ST_WR_B,
      ST_RD_AR,
      ST_RD_R,
      ST_RSP
   } state_e;

endpackage

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI-Lite master: one command in, one response out.
// Define AXI_LITE_MASTER_TIMEOUT_EN to abort B/R waits after TIMEOUT_CYC cycles.
module axi_lite_master
   import axi_lite_pkg::*;
#(
   parameter int TIMEOUT_CYC = 256
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [31:0] cmd_addr,
   input  logic [31:0] cmd_wdata,
   input  logic [3:0]  cmd_wstrb,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic [1:0]  rsp_resp,
   output logic        rsp_timeout,
   output logic [31:0] awaddr,
   output logic        awvalid,
   input  logic        awready,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic        wvalid,
   input  logic        wready,
   input  logic [1:0]  bresp,
   input  logic        bvalid,
   output logic        bready,
   output logic [31:0] araddr,
   output logic        arvalid,
   input  logic        arready,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rvalid,
   output logic        rready
);

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   localparam int TMO_W = $clog2(TIMEOUT_CYC) + 1;

   state_e           state;
   logic [TMO_W-1:0] tmo_cnt;
   logic             rsp_tmo_q;
   logic             aw_pend;
   logic             w_pend;
   logic             tmo_hit;

   // A channel stays pending until its own handshake; AW and W retire independently.
   assign aw_pend     = awvalid && !awready;
   assign w_pend      = wvalid && !wready;
   assign tmo_hit     = TMO_EN && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
   assign rsp_timeout = TMO_EN ? rsp_tmo_q : 1'b0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         cmd_ready <= 1'b0;
         awvalid   <= 1'b0;
         wvalid    <= 1'b0;
         bready    <= 1'b0;
         arvalid   <= 1'b0;
         rready    <= 1'b0;
         awaddr    <= '0;
         wdata     <= '0;
         wstrb     <= '0;
         araddr    <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_resp  <= '0;
         rsp_tmo_q <= 1'b0;
         tmo_cnt   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               cmd_ready <= 1'b1;
               if (cmd_valid && cmd_ready) begin
                  cmd_ready <= 1'b0;
                  if (cmd_write) begin
                     awaddr  <= cmd_addr;
                     wdata   <= cmd_wdata;
                     wstrb   <= cmd_wstrb;
                     awvalid <= 1'b1;
                     wvalid  <= 1'b1;
                     state   <= ST_WR_AW;
                  end else begin
                     araddr  <= cmd_addr;
                     arvalid <= 1'b1;
                     state   <= ST_RD_AR;
                  end
               end
            end
            ST_WR_AW: begin
               awvalid <= aw_pend;
               wvalid  <= w_pend;
               if (!aw_pend && !w_pend) begin
                  bready <= 1'b1;
                  state  <= ST_WR_B;
               end
            end
            ST_WR_B: begin
               if (bvalid && bready) begin
                  bready    <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_resp  <= bresp;
                  rsp_rdata <= '0;
                  rsp_tmo_q <= 1'b0;
                  tmo_cnt   <= '0;
                  state     <= ST_RSP;
               end else if (tmo_hit) begin
                  bready    <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_resp  <= RESP_SLVERR;
                  rsp_rdata <= '0;
                  rsp_tmo_q <= 1'b1;
                  tmo_cnt   <= '0;
                  state     <= ST_RSP;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            ST_RD_AR: begin
               if (arready) begin
                  arvalid <= 1'b0;
                  rready  <= 1'b1;
                  state   <= ST_RD_R;
               end
            end
            ST_RD_R: begin
               if (rvalid && rready) begin
                  rready    <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_resp  <= rresp;
                  rsp_rdata <= rdata;
                  rsp_tmo_q <= 1'b0;
                  tmo_cnt   <= '0;
                  state     <= ST_RSP;
               end else if (tmo_hit) begin
                  rready    <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_resp  <= RESP_SLVERR;
                  rsp_rdata <= '0;
                  rsp_tmo_q <= 1'b1;
                  tmo_cnt   <= '0;
                  state     <= ST_RSP;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            ST_RSP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  cmd_ready <= 1'b1;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_lite_master.sv
// Self-checking bench for axi_lite_master with a delay-configurable 4-register slave.
module tb_axi_lite_master;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, cmd_wdata;
   logic [3:0]  cmd_wstrb;
   logic        rsp_valid, rsp_ready, rsp_timeout;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic [31:0] awaddr, wdata, araddr, rdata;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [3:0]  wstrb;
   logic [1:0]  bresp, rresp;

   int checks = 0;
   int passed = 0;

   always #5 clk = ~clk;

   axi_lite_master #(.TIMEOUT_CYC(256)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
   );

   // ---------------- slave model ----------------
   logic [31:0] slv_mem [4];
   int  aw_delay = 0, w_delay = 0, ar_delay = 0, b_delay = 0, r_delay = 0;
   bit  b_never = 0, slv_clear = 0;
   logic aw_got, w_got, ar_got;
   int  aw_wait, w_wait, ar_wait, b_wait, r_wait;
   logic [31:0] aw_addr_l, w_data_l, ar_addr_l;
   logic [3:0]  w_strb_l;

   assign awready = awvalid && !aw_got && (aw_wait >= aw_delay);
   assign wready  = wvalid  && !w_got  && (w_wait  >= w_delay);
   assign arready = arvalid && !ar_got && (ar_wait >= ar_delay);

   always @(posedge clk or negedge rst_n) begin : slave
      logic aw_now, w_now, ar_now;
      logic [31:0] wa, wd, ra;
      logic [3:0]  ws;
      if (!rst_n || slv_clear) begin
         aw_got <= 0; w_got <= 0; ar_got <= 0;
         aw_wait <= 0; w_wait <= 0; ar_wait <= 0; b_wait <= 0; r_wait <= 0;
         bvalid <= 0; rvalid <= 0; bresp <= 0; rresp <= 0; rdata <= 0;
         aw_addr_l <= 0; w_data_l <= 0; w_strb_l <= 0; ar_addr_l <= 0;
      end else begin
         aw_now = aw_got || (awvalid && awready);
         w_now  = w_got  || (wvalid && wready);
         ar_now = ar_got || (arvalid && arready);
         wa = aw_got ? aw_addr_l : awaddr;
         wd = w_got ? w_data_l : wdata;
         ws = w_got ? w_strb_l : wstrb;
         ra = ar_got ? ar_addr_l : araddr;
         if (awvalid && awready) begin aw_got <= 1; aw_addr_l <= awaddr; end
         else if (awvalid && !aw_got) aw_wait <= aw_wait + 1;
         if (wvalid && wready) begin w_got <= 1; w_data_l <= wdata; w_strb_l <= wstrb; end
         else if (wvalid && !w_got) w_wait <= w_wait + 1;
         if (arvalid && arready) begin ar_got <= 1; ar_addr_l <= araddr; end
         else if (arvalid && !ar_got) ar_wait <= ar_wait + 1;
         if (!bvalid && aw_now && w_now && !b_never) begin
            if (b_wait >= b_delay) begin
               bvalid <= 1;
               if (wa < 32'h10) begin
                  for (int b = 0; b < 4; b++)
                     if (ws[b]) slv_mem[wa[3:2]][b*8 +: 8] <= wd[b*8 +: 8];
                  bresp <= 2'b00;
               end else bresp <= 2'b10;
            end else b_wait <= b_wait + 1;
         end
         if (bvalid && bready) begin
            bvalid <= 0; aw_got <= 0; w_got <= 0; aw_wait <= 0; w_wait <= 0; b_wait <= 0;
         end
         if (!rvalid && ar_now) begin
            if (r_wait >= r_delay) begin
               rvalid <= 1;
               if (ra < 32'h10) begin rdata <= slv_mem[ra[3:2]]; rresp <= 2'b00; end
               else if (ra == 32'h20) begin rdata <= 32'hDEADBEEF; rresp <= 2'b00; end
               else begin rdata <= 32'h0; rresp <= 2'b11; end
            end else r_wait <= r_wait + 1;
         end
         if (rvalid && rready) begin
            rvalid <= 0; ar_got <= 0; ar_wait <= 0; r_wait <= 0;
         end
      end
   end

   // ---------------- channel monitor ----------------
   bit mon_en = 0;
   int aw_hi, w_hi, b_hi, b_early;
   always @(negedge clk) begin
      if (!mon_en) begin
         aw_hi = 0; w_hi = 0; b_hi = 0; b_early = 0;
      end else begin
         if (awvalid) aw_hi++;
         if (wvalid) w_hi++;
         if (bready) b_hi++;
         if (bready && (awvalid || wvalid)) b_early++;
      end
   end

   // ---------------- reference model ----------------
   logic [31:0] exp_mem [4];

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] s);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
      return r;
   endfunction

   function automatic void model(input logic wr, input logic [31:0] a, input logic [31:0] d,
                                 input logic [3:0] s, output logic [31:0] erd,
                                 output logic [1:0] ers);
      erd = 32'h0;
      if (wr) begin
         if (a < 32'h10) begin exp_mem[a[3:2]] = merge(exp_mem[a[3:2]], d, s); ers = 2'b00; end
         else ers = 2'b10;
      end else if (a < 32'h10) begin erd = exp_mem[a[3:2]]; ers = 2'b00; end
      else if (a == 32'h20) begin erd = 32'hDEADBEEF; ers = 2'b00; end
      else ers = 2'b11;
   endfunction

   // ---------------- stimulus helpers (called at a negedge) ----------------
   task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output bit ok);
      int n = 0;
      cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1'b1;
      while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
      ok = cmd_ready;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(input int maxc, input int hold, output logic [31:0] rd,
                           output logic [1:0] rs, output logic to, output int lat,
                           output int unstable, output bit ok);
      lat = 1; unstable = 0;
      while (!rsp_valid && lat < maxc) begin @(negedge clk); lat++; end
      ok = rsp_valid; rd = rsp_rdata; rs = rsp_resp; to = rsp_timeout;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         if (!rsp_valid || rsp_rdata !== rd || rsp_resp !== rs || rsp_timeout !== to) unstable++;
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      #23;
      checks++; if ({cmd_ready, awvalid, wvalid, arvalid, bready, rready} !== 6'b0)
         $display("FAIL reset_valids got=%b want=000000", {cmd_ready, awvalid, wvalid, arvalid, bready, rready}); else passed++;
      checks++; if (rsp_valid !== 1'b0 || rsp_timeout !== 1'b0)
         $display("FAIL reset_rsp_valid got=%b%b want=00", rsp_valid, rsp_timeout); else passed++;
      checks++; if ({rsp_rdata, rsp_resp} !== 34'h0)
         $display("FAIL reset_rsp_data got=%h want=0", {rsp_rdata, rsp_resp}); else passed++;
      checks++; if ({awaddr, wdata, wstrb, araddr} !== 100'h0)
         $display("FAIL reset_regs got=%h want=0", {awaddr, wdata, wstrb, araddr}); else passed++;
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk); @(negedge clk);
      checks++; if (cmd_ready !== 1'b1)
         $display("FAIL idle_cmd_ready got=%b want=1", cmd_ready); else passed++;
   endtask

   task automatic test_single();
      logic [31:0] rd, erd; logic [1:0] rs, ers; logic to; int lat, un; bit ok, ok2;
      issue(1'b1, 32'h0, 32'hA5A50000, 4'hF, ok);
      wait_rsp(50, 0, rd, rs, to, lat, un, ok2);
      model(1'b1, 32'h0, 32'hA5A50000, 4'hF, erd, ers);
      checks++; if (!(ok && ok2) || rs !== ers || rd !== 32'h0 || to !== 1'b0)
         $display("FAIL single_write got=resp %b rdata %h tmo %b want=resp %b rdata 0 tmo 0", rs, rd, to, ers); else passed++;
      checks++; if (lat !== 3)
         $display("FAIL write_latency got=%0d want=3", lat); else passed++;
      issue(1'b0, 32'h0, 32'h0, 4'h0, ok);
      wait_rsp(50, 0, rd, rs, to, lat, un, ok2);
      model(1'b0, 32'h0, 32'h0, 4'h0, erd, ers);
      checks++; if (!(ok && ok2) || rd !== 32'hA5A50000 || rs !== 2'b00)
         $display("FAIL single_read got=%h/%b want=a5a50000/00", rd, rs); else passed++;
      checks++; if (lat !== 3)
         $display("FAIL read_latency got=%0d want=3", lat); else passed++;
   endtask

   task automatic test_four_regs();
      logic [31:0] rd, erd; logic [1:0] rs, ers; logic to; int lat, un; bit ok, ok2;
      for (int i = 0; i < 4; i++) begin
         issue(1'b1, 32'(4 * i), 32'hA5A50000 + 32'(i), 4'hF, ok);
         wait_rsp(50, 0, rd, rs, to, lat, un, ok2);
         model(1'b1, 32'(4 * i), 32'hA5A50000 + 32'(i), 4'hF, erd, ers);
         checks++; if (!(ok && ok2) || rs !== 2'b00)
            $display("FAIL four_write[%0d] got=%b want=00", i, rs); else passed++;
      end
      for (int i = 0; i < 4; i++) begin
         issue(1'b0, 32'(4 * i), 32'h0, 4'h0, ok);
         wait_rsp(50, 0, rd, rs, to, lat, un, ok2);
         checks++; if (!(ok && ok2) || rd !== 32'hA5A50000 + 32'(i) || rs !== 2'b00)
            $display("FAIL four_read[%0d] got=%h/%b want=%h/00", i, rd, rs, 32'hA5A50000 + 32'(i)); else passed++;
      end
   endtask

   task automatic test_deadbeef();
      logic [31:0] rd; logic [1:0] rs; logic to; int lat, un; bit ok, ok2;
      issue(1'b0, 32'h20, 32'h0, 4'h0, ok);
      wait_rsp(50, 0, rd, rs, to, lat, un, ok2);
      checks++; if (!(ok && ok2) || rd !== 32'hDEADBEEF || rs !== 2'b00)
         $display("FAIL read_0x20 got=%h/%b want=deadbeef/00", rd, rs); else passed++;
   endtask

   task automatic test_aw_delay();
      logic [31:0] rd, erd; logic [1:0] rs, ers; logic to; int lat, un; bit ok, ok2;
      aw_delay = 3; w_delay = 0;
      mon_en = 1;
      issue(1'b1, 32'hC, 32'h1234ABCD, 4'hF, ok);
      wait_rsp(50, 5, rd, rs, to, lat, un, ok2);
      mon_en = 0;
      model(1'b1, 32'hC, 32'h1234ABCD, 4'hF, erd, ers);
      checks++; if (w_hi !== 1)
         $display("FAIL wvalid_cycles got=%0d want=1", w_hi); else passed++;
      checks++; if (aw_hi !== 4)
         $display("FAIL awvalid_cycles got=%0d want=4", aw_hi); else passed++;
      checks++; if (b_early !== 0 || b_hi < 1)
         $display("FAIL bready_order got=early %0d seen %0d want=early 0 seen>=1", b_early, b_hi); else passed++;
      checks++; if (un !== 0)
         $display("FAIL rsp_stable got=%0d unstable cycles want=0", un); else passed++;
      checks++; if (!(ok && ok2) || rs !== ers)
         $display("FAIL aw_delay_resp got=%b want=%b", rs, ers); else passed++;
      aw_delay = 0;
   endtask

   task automatic test_timeout();
      logic [31:0] rd, erd; logic [1:0] rs, ers; logic to; int lat, un; bit ok, ok2;
      b_never = 1;
      mon_en = 1;
      issue(1'b1, 32'h8, 32'h0BAD0BAD, 4'hF, ok);
`ifdef AXI_LITE_MASTER_TIMEOUT_EN
      wait_rsp(400, 0, rd, rs, to, lat, un, ok2);
      mon_en = 0;
      checks++; if (!(ok && ok2) || rs !== 2'b10 || to !== 1'b1 || rd !== 32'h0)
         $display("FAIL timeout_rsp got=%b/%b/%h want=10/1/0", rs, to, rd); else passed++;
      checks++; if (b_hi !== 256)
         $display("FAIL timeout_bready_cycles got=%0d want=256", b_hi); else passed++;
      checks++; if (cmd_ready !== 1'b1 || bready !== 1'b0)
         $display("FAIL timeout_idle got=cmd_ready %b bready %b want=1 0", cmd_ready, bready); else passed++;
      slv_clear = 1; @(negedge clk); slv_clear = 0;
      b_never = 0;
`else
      begin
         int seen = 0;
         for (int i = 0; i < 300; i++) begin @(negedge clk); if (rsp_valid) seen++; end
         checks++; if (seen !== 0 || bready !== 1'b1)
            $display("FAIL no_timeout_wait got=rsp seen %0d bready %b want=0 1", seen, bready); else passed++;
      end
      b_never = 0;
      wait_rsp(50, 0, rd, rs, to, lat, un, ok2);
      mon_en = 0;
      model(1'b1, 32'h8, 32'h0BAD0BAD, 4'hF, erd, ers);
      checks++; if (!(ok && ok2) || rs !== ers || to !== 1'b0)
         $display("FAIL late_b_rsp got=%b/%b want=%b/0", rs, to, ers); else passed++;
`endif
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd, erd; logic [1:0] rs, ers; logic to; int lat, un, n; bit ok, ok2;
      r_delay = 20;
      issue(1'b0, 32'h4, 32'h0, 4'h0, ok);
      n = 0;
      while (!rready && n < 20) begin @(negedge clk); n++; end
      checks++; if (rready !== 1'b1)
         $display("FAIL reach_rd_r got=rready %b want=1", rready); else passed++;
      #2 rst_n = 1'b0;
      #1;
      checks++; if ({cmd_ready, arvalid, rready, rsp_valid, awvalid, wvalid, bready} !== 7'b0)
         $display("FAIL async_reset_ctrl got=%b want=0", {cmd_ready, arvalid, rready, rsp_valid, awvalid, wvalid, bready}); else passed++;
      checks++; if ({araddr, rsp_rdata, rsp_resp, rsp_timeout} !== 67'h0)
         $display("FAIL async_reset_data got=%h want=0", {araddr, rsp_rdata, rsp_resp, rsp_timeout}); else passed++;
      r_delay = 0;
      @(negedge clk); rst_n = 1'b1;
      n = 0;
      for (int i = 0; i < 4; i++) begin @(negedge clk); if (rsp_valid) n++; end
      checks++; if (n !== 0)
         $display("FAIL abandoned_rsp got=%0d want=0", n); else passed++;
      issue(1'b0, 32'h4, 32'h0, 4'h0, ok);
      wait_rsp(50, 0, rd, rs, to, lat, un, ok2);
      model(1'b0, 32'h4, 32'h0, 4'h0, erd, ers);
      checks++; if (!(ok && ok2) || rd !== erd || rs !== ers)
         $display("FAIL post_reset_read got=%h/%b want=%h/%b", rd, rs, erd, ers); else passed++;
   endtask

   task automatic test_random();
      logic [31:0] addrs [6];
      logic [31:0] a, d, rd, erd; logic [3:0] s; logic [1:0] rs, ers; logic wr, to;
      int lat, un, un_tot; bit ok, ok2;
      addrs[0] = 32'h0; addrs[1] = 32'h4; addrs[2] = 32'h8;
      addrs[3] = 32'hC; addrs[4] = 32'h20; addrs[5] = 32'h40;
      un_tot = 0;
      for (int t = 0; t < 40; t++) begin
         wr = 1'($urandom_range(0, 1));
         a = addrs[$urandom_range(0, 5)];
         d = $urandom;
         s = 4'($urandom_range(0, 15));
         aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3);
         ar_delay = $urandom_range(0, 3); b_delay = $urandom_range(0, 3);
         r_delay = $urandom_range(0, 3);
         issue(wr, a, d, s, ok);
         wait_rsp(60, $urandom_range(0, 2), rd, rs, to, lat, un, ok2);
         model(wr, a, d, s, erd, ers);
         un_tot += un;
         checks++; if (!(ok && ok2) || rd !== erd || rs !== ers || to !== 1'b0)
            $display("FAIL random[%0d] wr=%b addr=%h got=%h/%b/%b want=%h/%b/0", t, wr, a, rd, rs, to, erd, ers); else passed++;
      end
      checks++; if (un_tot !== 0)
         $display("FAIL random_rsp_stable got=%0d want=0", un_tot); else passed++;
      aw_delay = 0; w_delay = 0; ar_delay = 0; b_delay = 0; r_delay = 0;
   endtask

   initial begin
      cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
      rsp_ready = 0;
      for (int i = 0; i < 4; i++) exp_mem[i] = 32'h0;
      test_reset();
      test_single();
      test_four_regs();
      test_deadbeef();
      test_aw_delay();
      test_timeout();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_time_limit got=expired want=finish");
      $fatal(1, "time limit");
   end

endmodule
